// File: rtl/fdiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fdiv_pkg
// Description : Shared types and defaults for the fdiv_ctrl clock divider
//               controller and its counter core.
// Revision    : 1.0 - initial release
// ============================================================================
package fdiv_pkg;

    // Default half-period counter width (fits 25_000_000).
    localparam int DEF_CNT_W    = 26;

    // Half-period giving 1 Hz from a 50 MHz system clock.
    localparam int DEF_HALF_1HZ = 25000000;

    // Controller states: stopped, running, running with a divisor waiting
    // for the next falling boundary.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } fdiv_state_t;

endpackage : fdiv_pkg
`default_nettype wire

// File: rtl/fdiv_core.sv
`default_nettype none
// ============================================================================
// Module      : fdiv_core
// Description : Half-period counter with terminal-count compare. Toggles a
//               registered 50%-duty clk_out at every terminal count, pulses
//               tick on each rising toggle and reports the falling boundary
//               (terminal count while clk_out is high) to the controller.
//               The counter and clk_out are held at zero whenever the core
//               is disabled or cleared.
// Revision    : 1.0 - initial release
// ============================================================================
module fdiv_core
    import fdiv_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] half,
    input  logic             en,
    input  logic             clr,
    output logic             clk_out,
    output logic             tick,
    output logic             fall
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_last;
    logic             w_count;
    logic             w_tc;

    // Terminal value is half-1; half is never zero, so no underflow.
    assign w_last  = half - CNT_W'(1);
    assign w_count = en & ~clr;
    assign w_tc    = w_count & (r_cnt == w_last);

    // Falling boundary: the toggle that will take clk_out from 1 to 0.
    assign fall    = w_tc & clk_out;

    // Counter, divided clock and rise tick; cleared to a known low phase
    // whenever counting is not active.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else if (!w_count) begin
            r_cnt   <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else if (w_tc) begin
            r_cnt   <= '0;
            clk_out <= ~clk_out;
            tick    <= ~clk_out;
        end else begin
            r_cnt   <= r_cnt + CNT_W'(1);
            tick    <= 1'b0;
        end
    end

endmodule : fdiv_core
`default_nettype wire

// File: rtl/fdiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fdiv_ctrl
// Description : Run/stop and reconfiguration controller for the board clock
//               divider. Accepts new half-periods over a valid/ready port and
//               applies them only at falling boundaries so clk_out never
//               glitches. A zero divisor is accepted, discarded and flagged.
//               Optional feature macro: FDIV_SYNC_CLR_EN adds a sync_clr input
//               that restarts the output phase (run=0 takes priority).
// Revision    : 1.0 - initial release
// ============================================================================
module fdiv_ctrl
    import fdiv_pkg::*;
#(
    parameter int          CNT_W   = DEF_CNT_W,
    parameter int unsigned DEF_DIV = DEF_HALF_1HZ
) (
    input  logic             clk_50mHz,
    input  logic             rst,
    input  logic             run,
    input  logic             cfg_valid,
`ifdef FDIV_SYNC_CLR_EN
    input  logic             sync_clr,
`endif
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             clk_out,
    output logic             tick,
    output logic             busy,
    output logic             err
);

    localparam logic [CNT_W-1:0] c_def_half = CNT_W'(DEF_DIV);

    fdiv_state_t      r_state;
    fdiv_state_t      w_state_nxt;
    logic [CNT_W-1:0] r_half;
    logic [CNT_W-1:0] w_half_nxt;
    logic [CNT_W-1:0] r_pend;
    logic [CNT_W-1:0] w_pend_nxt;
    logic             w_hs;
    logic             w_zero;
    logic             w_legal;
    logic             w_fall;
    logic             w_sync_clr;
    logic             w_core_en;

`ifdef FDIV_SYNC_CLR_EN
    assign w_sync_clr = sync_clr;
`else
    assign w_sync_clr = 1'b0;
`endif

    // Handshake; cfg_ready is the registered image of (state != PEND).
    assign w_hs    = cfg_valid & cfg_ready;
    assign w_zero  = (cfg_div == '0);
    assign w_legal = w_hs & ~w_zero;

    // Counting only in RUN/PEND with run held; run=0 clears the phase at once.
    assign w_core_en = (r_state != IDLE) & run;

    fdiv_core #(
        .CNT_W (CNT_W)
    ) u_core (
        .clk     (clk_50mHz),
        .rst     (rst),
        .half    (r_half),
        .en      (w_core_en),
        .clr     (w_sync_clr),
        .clk_out (clk_out),
        .tick    (tick),
        .fall    (w_fall)
    );

    // State, divisor registers and registered handshake/status outputs.
    always_ff @(posedge clk_50mHz or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_half    <= c_def_half;
            r_pend    <= '0;
            cfg_ready <= 1'b1;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_half    <= w_half_nxt;
            r_pend    <= w_pend_nxt;
            cfg_ready <= (w_state_nxt != PEND);
            busy      <= (w_state_nxt == PEND);
            err       <= w_hs & w_zero;
        end
    end

    // Next-state and divisor update; pending values land only at a falling
    // boundary, a stop, or a phase clear so the new period starts low.
    always_comb begin
        w_state_nxt = r_state;
        w_half_nxt  = r_half;
        w_pend_nxt  = r_pend;
        unique case (r_state)
            IDLE: begin
                if (w_legal) begin
                    w_half_nxt = cfg_div;
                end
                if (run) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (!run) begin
                    w_state_nxt = IDLE;
                    if (w_legal) begin
                        w_half_nxt = cfg_div;
                    end
                end else if (w_legal) begin
                    // Also covers a handshake on a falling boundary: it waits
                    // for the following boundary.
                    w_state_nxt = PEND;
                    w_pend_nxt  = cfg_div;
                end
            end
            PEND: begin
                if (!run) begin
                    w_state_nxt = IDLE;
                    w_half_nxt  = r_pend;
                end else if (w_sync_clr || w_fall) begin
                    w_state_nxt = RUN;
                    w_half_nxt  = r_pend;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

endmodule : fdiv_ctrl
`default_nettype wire

// File: tb/tb_fdiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fdiv_ctrl
// Description : Self-checking bench for fdiv_ctrl (DEF_DIV=4, CNT_W=8).
//               Expected fall-to-fall periods are queued as stimulus is
//               applied and checked as each falling edge of clk_out appears.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fdiv_ctrl;

    localparam int c_cnt_w = 8;

    typedef struct {
        int len;
        int high;
    } exp_t;

    logic               clk;
    logic               rst;
    logic               run;
    logic               cfg_valid;
    logic               sync_clr;
    logic [c_cnt_w-1:0] cfg_div;
    logic               cfg_ready;
    logic               clk_out;
    logic               tick;
    logic               busy;
    logic               err;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t sb[$];

    // Monitor state, updated only by sample().
    bit   cur = 0;
    bit   prev = 0;
    bit   fall_flag = 0;
    int   last_fall = 0;
    int   hi_run = 0;
    int   ticks_run = 0;
    int   bad_run = 0;
    int   p_len = 0;
    int   p_high = 0;
    int   p_ticks = 0;
    int   p_bad = 0;

    fdiv_ctrl #(
        .CNT_W   (c_cnt_w),
        .DEF_DIV (4)
    ) dut (
        .clk_50mHz (clk),
        .rst       (rst),
        .run       (run),
        .cfg_valid (cfg_valid),
`ifdef FDIV_SYNC_CLR_EN
        .sync_clr  (sync_clr),
`endif
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .clk_out   (clk_out),
        .tick      (tick),
        .busy      (busy),
        .err       (err)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // One negedge step; tracks clk_out phases and closes a period at each fall.
    task automatic sample();
        @(negedge clk);
        prev      = cur;
        cur       = clk_out;
        fall_flag = 0;
        if (tick) ticks_run++;
        if (tick !== (cur && !prev)) bad_run++;
        if (prev && !cur) begin
            p_len     = cyc - last_fall;
            p_high    = hi_run;
            p_ticks   = ticks_run;
            p_bad     = bad_run;
            last_fall = cyc;
            hi_run    = 0;
            ticks_run = 0;
            bad_run   = 0;
            fall_flag = 1;
        end
        if (cur) hi_run++;
    endtask

    task automatic wait_fall(input string name);
        bit got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            sample();
            if (fall_flag) got = 1;
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL %s: no clk_out fall within 200 cycles", name);
        end
    endtask

    task automatic wait_rise(input string name);
        bit got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            sample();
            if (cur && !prev) got = 1;
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL %s: no clk_out rise within 200 cycles", name);
        end
    endtask

    // Wait for the next fall and compare the finished period with the queue.
    task automatic check_period(input string name);
        exp_t e;
        bit   got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            sample();
            if (fall_flag) got = 1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s: no clk_out fall within 200 cycles", name);
        end else if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s: period seen with empty scoreboard, len=%0d", name, p_len);
        end else begin
            e = sb.pop_front();
            if (p_len !== e.len) begin
                errors++;
                $display("FAIL %s period: got %0d cycles, expected %0d", name, p_len, e.len);
            end
            checks++;
            if (p_high !== e.high) begin
                errors++;
                $display("FAIL %s high: got %0d cycles, expected %0d", name, p_high, e.high);
            end
            checks++;
            if (p_ticks !== 1) begin
                errors++;
                $display("FAIL %s ticks: got %0d, expected 1", name, p_ticks);
            end
            checks++;
            if (p_bad !== 0) begin
                errors++;
                $display("FAIL %s tick_align: got %0d misaligned samples, expected 0", name, p_bad);
            end
        end
    endtask

    task automatic push_exp(input int len, input int high);
        exp_t e;
        e.len  = len;
        e.high = high;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        rst = 1'b1; run = 1'b0; cfg_valid = 1'b0; cfg_div = '0; sync_clr = 1'b0;
        sample();
        checks++; if (clk_out !== 1'b0)   begin errors++; $display("FAIL rst_clk_out: got %b expected 0", clk_out); end
        checks++; if (tick !== 1'b0)      begin errors++; $display("FAIL rst_tick: got %b expected 0", tick); end
        checks++; if (err !== 1'b0)       begin errors++; $display("FAIL rst_err: got %b expected 0", err); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL rst_cfg_ready: got %b expected 1", cfg_ready); end
        rst = 1'b0;
        sample();
        sample();
        checks++; if (clk_out !== 1'b0)   begin errors++; $display("FAIL idle_clk_out: got %b expected 0", clk_out); end
    endtask

    task automatic test_basic();
        int  c0;
        bit  got = 0;
        run = 1'b1;
        c0  = cyc;
        for (int i = 0; i < 50 && !got; i++) begin
            sample();
            if (tick) got = 1;
        end
        checks++;
        if (!got || (cyc - c0) !== 5) begin
            errors++;
            $display("FAIL first_rise: got tick at +%0d cycles (seen=%0d), expected +5", cyc - c0, got);
        end
        wait_fall("basic_sync");
        push_exp(8, 4);
        push_exp(8, 4);
        check_period("basic_p1");
        check_period("basic_p2");
    endtask

    task automatic test_zero();
        cfg_valid = 1'b1; cfg_div = 8'd0;
        sample();
        cfg_valid = 1'b0;
        checks++; if (err !== 1'b1)       begin errors++; $display("FAIL zero_err: got %b expected 1", err); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL zero_busy: got %b expected 0", busy); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL zero_ready: got %b expected 1", cfg_ready); end
        sample();
        checks++; if (err !== 1'b0)       begin errors++; $display("FAIL zero_err_pulse: got %b expected 0", err); end
        push_exp(8, 4);
        check_period("zero_p");
    endtask

    task automatic test_reconfig();
        wait_rise("reconf_rise");
        sample();
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reconf_ready_pre: got %b expected 1", cfg_ready); end
        cfg_valid = 1'b1; cfg_div = 8'd2;
        sample();
        cfg_valid = 1'b0;
        checks++; if (busy !== 1'b1)      begin errors++; $display("FAIL reconf_busy: got %b expected 1", busy); end
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL reconf_ready: got %b expected 0", cfg_ready); end
        push_exp(8, 4);
        push_exp(4, 2);
        push_exp(4, 2);
        check_period("reconf_old");
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reconf_busy_drop: got %b expected 0", busy); end
        check_period("reconf_new1");
        check_period("reconf_new2");
    endtask

    task automatic test_stop();
        int highs = 0;
        wait_rise("stop_rise");
        cfg_valid = 1'b1; cfg_div = 8'd3;
        sample();
        cfg_valid = 1'b0;
        checks++; if (busy !== 1'b1)      begin errors++; $display("FAIL stop_busy_pre: got %b expected 1", busy); end
        sample();
        run = 1'b0;
        sample();
        checks++; if (clk_out !== 1'b0)   begin errors++; $display("FAIL stop_clk_out: got %b expected 0", clk_out); end
        checks++; if (tick !== 1'b0)      begin errors++; $display("FAIL stop_tick: got %b expected 0", tick); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL stop_busy: got %b expected 0", busy); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL stop_ready: got %b expected 1", cfg_ready); end
        for (int i = 0; i < 4; i++) begin
            sample();
            if (clk_out) highs++;
        end
        checks++; if (highs !== 0)        begin errors++; $display("FAIL stop_hold: got %0d high samples expected 0", highs); end
        run = 1'b1;
        wait_fall("stop_sync");
        push_exp(6, 3);
        check_period("stop_p");
    endtask

    task automatic test_rst_pend();
        wait_rise("rstp_rise");
        cfg_valid = 1'b1; cfg_div = 8'd5;
        sample();
        cfg_valid = 1'b0;
        checks++; if (busy !== 1'b1)      begin errors++; $display("FAIL rstp_busy_pre: got %b expected 1", busy); end
        checks++; if (clk_out !== 1'b1)   begin errors++; $display("FAIL rstp_high_pre: got %b expected 1", clk_out); end
        #5 rst = 1'b1;
        #1;
        checks++; if (clk_out !== 1'b0)   begin errors++; $display("FAIL rstp_clk_out: got %b expected 0", clk_out); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL rstp_busy: got %b expected 0", busy); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL rstp_ready: got %b expected 1", cfg_ready); end
        sample();
        rst = 1'b0;
        wait_fall("rstp_sync");
        push_exp(8, 4);
        check_period("rstp_p");
    endtask

    task automatic test_hs_at_fall();
        wait_rise("hsf_rise");
        sample();
        sample();
        sample();
        cfg_valid = 1'b1; cfg_div = 8'd2;
        sample();
        cfg_valid = 1'b0;
        checks++; if (fall_flag !== 1'b1) begin errors++; $display("FAIL hsf_fall: got %b expected 1", fall_flag); end
        checks++; if (busy !== 1'b1)      begin errors++; $display("FAIL hsf_busy: got %b expected 1", busy); end
        push_exp(8, 4);
        push_exp(4, 2);
        check_period("hsf_old");
        check_period("hsf_new");
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL hsf_busy_drop: got %b expected 0", busy); end
    endtask

    task automatic test_div1();
        cfg_valid = 1'b1; cfg_div = 8'd1;
        sample();
        cfg_valid = 1'b0;
        checks++; if (busy !== 1'b1)      begin errors++; $display("FAIL div1_busy: got %b expected 1", busy); end
        wait_fall("div1_sync");
        push_exp(2, 1);
        push_exp(2, 1);
        push_exp(2, 1);
        check_period("div1_p1");
        check_period("div1_p2");
        check_period("div1_p3");
`ifdef FDIV_SYNC_CLR_EN
        sync_clr = 1'b1;
        sample();
        sync_clr = 1'b0;
        checks++; if (clk_out !== 1'b0)   begin errors++; $display("FAIL sclr_clk_out: got %b expected 0", clk_out); end
        checks++; if (tick !== 1'b0)      begin errors++; $display("FAIL sclr_tick: got %b expected 0", tick); end
        sample();
        checks++; if (clk_out !== 1'b1)   begin errors++; $display("FAIL sclr_rise: got %b expected 1", clk_out); end
        checks++; if (tick !== 1'b1)      begin errors++; $display("FAIL sclr_rise_tick: got %b expected 1", tick); end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_reconfig();
        test_stop();
        test_rst_pend();
        test_hs_at_fall();
        test_div1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_fdiv_ctrl
`default_nettype wire
